// File: rtl/xbar_pkg.sv
// Shared encodings for the crossbar program/verify engine: ops, response
// status codes, FSM states and the row one-hot helper.
package xbar_pkg;

    typedef enum logic [1:0] {
        OP_READ        = 2'd0,
        OP_PROG_VERIFY = 2'd1,
        OP_FORM        = 2'd2,
        OP_RSVD        = 2'd3
    } op_e;

    typedef enum logic [2:0] {
        RS_OK          = 3'd0,
        RS_VERIFY_FAIL = 3'd1,
        RS_INTERLOCK   = 3'd2,
        RS_ABORTED     = 3'd3,
        RS_RANGE       = 3'd4,
        RS_BAD_OP      = 3'd5
    } status_e;

    // Sampling happens on the last RD_SETTLE edge, so no separate SAMPLE cycle.
    typedef enum logic [2:0] {
        S_IDLE      = 3'd0,
        S_RD_SETTLE = 3'd1,
        S_PULSE     = 3'd2,
        S_GAP       = 3'd3,
        S_RESP      = 3'd4
    } state_e;

    function automatic logic [31:0] onehot_row(input int unsigned row);
        return 32'd1 << row;
    endfunction

endpackage

// File: rtl/xbar_pv_engine_if.sv
// Command/response handshake bundle between the host decoder (master) and
// the crossbar engine (slave).
interface xbar_pv_engine_if #(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int TRY_W = 4
) ();
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_op;
    logic [ROW_W-1:0] cmd_row;
    logic [COL_W-1:0] cmd_col;
    logic             cmd_pol;
    logic             cmd_target;
    logic [TRY_W-1:0] cmd_max_tries;
    logic             rsp_valid;
    logic             rsp_ready;
    logic [2:0]       rsp_status;
    logic [COLS-1:0]  rsp_data;
    logic [TRY_W-1:0] rsp_tries;

    modport master (
        output cmd_valid, cmd_op, cmd_row, cmd_col, cmd_pol, cmd_target, cmd_max_tries, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_status, rsp_data, rsp_tries
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_row, cmd_col, cmd_pol, cmd_target, cmd_max_tries, rsp_ready,
        output cmd_ready, rsp_valid, rsp_status, rsp_data, rsp_tries
    );
endinterface

// File: rtl/xbar_pulse_timer.sv
// Loadable down-counter shared by the pulse and read-settle phases; done is
// high while the count sits at zero.
module xbar_pulse_timer #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] value,
    input  logic             tick,
    output logic             done
);
    logic [CNT_W-1:0] count_q, count_d;

    assign done = (count_q == '0);

    always_comb begin
        count_d = count_q;
        if (load)
            count_d = value;
        else if (tick && !done)
            count_d = count_q - 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count_q <= '0;
        else
            count_q <= count_d;
    end
endmodule

// File: rtl/xbar_pv_engine.sv
// Cell-level READ / PROG_VERIFY / FORM sequencer for a ROWS x COLS memristor
// crossbar, driving row pads and sampling column comparators.
module xbar_pv_engine
    import xbar_pkg::*;
#(
    parameter int ROWS  = 8,
    parameter int COLS  = 8,
    parameter int CNT_W = 16,
    parameter int TRY_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    xbar_pv_engine_if.slave    bus,
    input  logic [CNT_W-1:0]   pulse_width,
    input  logic [CNT_W-1:0]   form_width,
    input  logic [CNT_W-1:0]   settle_cycles,
    input  logic               prog_en,
    output logic [ROWS-1:0]    row_drive,
    output logic               row_oe,
    input  logic [COLS-1:0]    col_sense,
    output logic               busy
);
    localparam int ROW_W = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int COL_W = (COLS > 1) ? $clog2(COLS) : 1;

    state_e           state_q, state_d;
    op_e              op_q, op_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             pol_q, pol_d;
    logic             tgt_q, tgt_d;
    logic [TRY_W-1:0] max_q, max_d;
    logic [CNT_W-1:0] pw_q, pw_d;
    logic [CNT_W-1:0] sl_q, sl_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    status_e          status_q, status_d;
    logic [COLS-1:0]  data_q, data_d;
    logic [ROWS-1:0]  row_drive_q, row_drive_d;

    logic             tmr_load, tmr_tick, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic [CNT_W-1:0] ld_prog, ld_form, ld_settle;
    logic [ROWS-1:0]  oh_row;
    logic             in_range;

    xbar_pulse_timer #(.CNT_W(CNT_W)) u_pulse_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (tmr_load),
        .value (tmr_val),
        .tick  (tmr_tick),
        .done  (tmr_done)
    );

    assign ld_prog   = (pulse_width   == '0) ? '0 : pulse_width   - 1'b1;
    assign ld_form   = (form_width    == '0) ? '0 : form_width    - 1'b1;
    assign ld_settle = (settle_cycles == '0) ? '0 : settle_cycles - 1'b1;
    assign in_range  = (int'(bus.cmd_row) < ROWS) && (int'(bus.cmd_col) < COLS);

    always_comb begin
        state_d  = state_q;
        op_d     = op_q;
        row_d    = row_q;
        col_d    = col_q;
        pol_d    = pol_q;
        tgt_d    = tgt_q;
        max_d    = max_q;
        pw_d     = pw_q;
        sl_d     = sl_q;
        tries_d  = tries_q;
        status_d = status_q;
        data_d   = data_q;
        tmr_load = 1'b0;
        tmr_tick = 1'b0;
        tmr_val  = '0;

        unique case (state_q)
            S_IDLE: begin
                if (bus.cmd_valid) begin
                    op_d     = op_e'(bus.cmd_op);
                    row_d    = bus.cmd_row;
                    col_d    = bus.cmd_col;
                    pol_d    = bus.cmd_pol;
                    tgt_d    = bus.cmd_target;
                    max_d    = (bus.cmd_max_tries == '0) ? TRY_W'(1) : bus.cmd_max_tries;
                    pw_d     = (bus.cmd_op == OP_FORM) ? ld_form : ld_prog;
                    sl_d     = ld_settle;
                    tries_d  = '0;
                    status_d = RS_OK;
                    data_d   = '0;
                    if (bus.cmd_op == OP_RSVD) begin
                        status_d = RS_BAD_OP;
                        state_d  = S_RESP;
                    end else if (!in_range) begin
                        status_d = RS_RANGE;
                        state_d  = S_RESP;
                    end else if (bus.cmd_op != OP_READ && !prog_en) begin
                        status_d = RS_INTERLOCK;
                        state_d  = S_RESP;
                    end else if (bus.cmd_op == OP_FORM) begin
                        tries_d  = TRY_W'(1);
                        tmr_load = 1'b1;
                        tmr_val  = ld_form;
                        state_d  = S_PULSE;
                    end else begin
                        tmr_load = 1'b1;
                        tmr_val  = ld_settle;
                        state_d  = S_RD_SETTLE;
                    end
                end
            end
            S_RD_SETTLE: begin
                tmr_tick = 1'b1;
                if (tmr_done) begin
                    data_d = col_sense;
                    if (op_q == OP_READ || col_sense[col_q] == tgt_q) begin
                        state_d = S_RESP;
                    end else if (tries_q == max_q) begin
                        status_d = RS_VERIFY_FAIL;
                        state_d  = S_RESP;
                    end else begin
                        tries_d  = tries_q + 1'b1;
                        tmr_load = 1'b1;
                        tmr_val  = pw_q;
                        state_d  = S_PULSE;
                    end
                end
            end
            S_PULSE: begin
                tmr_tick = 1'b1;
                if (!prog_en) begin
                    status_d = RS_ABORTED;
                    state_d  = S_RESP;
                end else if (tmr_done) begin
                    state_d = (op_q == OP_FORM) ? S_RESP : S_GAP;
                end
            end
            S_GAP: begin
                tmr_load = 1'b1;
                tmr_val  = sl_q;
                state_d  = S_RD_SETTLE;
            end
            S_RESP: begin
                if (bus.rsp_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Pad drive is registered from the next state so it toggles cleanly on the edge.
    assign oh_row = ROWS'(onehot_row(32'(row_d)));

    always_comb begin
        row_drive_d = '0;
        if (state_d == S_RD_SETTLE)
            row_drive_d = oh_row;
        else if (state_d == S_PULSE)
            row_drive_d = (op_d == OP_FORM || pol_d) ? oh_row : ~oh_row;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            op_q        <= OP_READ;
            row_q       <= '0;
            col_q       <= '0;
            pol_q       <= 1'b0;
            tgt_q       <= 1'b0;
            max_q       <= '0;
            pw_q        <= '0;
            sl_q        <= '0;
            tries_q     <= '0;
            status_q    <= RS_OK;
            data_q      <= '0;
            row_drive_q <= '0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            row_q       <= row_d;
            col_q       <= col_d;
            pol_q       <= pol_d;
            tgt_q       <= tgt_d;
            max_q       <= max_d;
            pw_q        <= pw_d;
            sl_q        <= sl_d;
            tries_q     <= tries_d;
            status_q    <= status_d;
            data_q      <= data_d;
            row_drive_q <= row_drive_d;
        end
    end

    assign row_drive      = row_drive_q;
    assign row_oe         = 1'b1;
    assign busy           = (state_q != S_IDLE);
    assign bus.cmd_ready  = (state_q == S_IDLE);
    assign bus.rsp_valid  = (state_q == S_RESP);
    assign bus.rsp_status = status_q;
    assign bus.rsp_data   = data_q;
    assign bus.rsp_tries  = tries_q;
endmodule

// File: tb/tb_xbar_pv_engine.sv
// Randomised bench for xbar_pv_engine: a small cell environment drives col_sense,
// and a step-list reference model predicts drive trace, latency and response.
module tb_xbar_pv_engine;
    localparam int ROWS  = 6;
    localparam int COLS  = 6;
    localparam int CNT_W = 16;
    localparam int TRY_W = 4;
    localparam int ROW_W = $clog2(ROWS);
    localparam int COL_W = $clog2(COLS);

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic [CNT_W-1:0] pulse_width, form_width, settle_cycles;
    logic             prog_en;
    logic [ROWS-1:0]  row_drive;
    logic             row_oe;
    logic [COLS-1:0]  col_sense;
    logic             busy;

    xbar_pv_engine_if #(.ROWS(ROWS), .COLS(COLS), .TRY_W(TRY_W)) bus ();

    xbar_pv_engine #(.ROWS(ROWS), .COLS(COLS), .CNT_W(CNT_W), .TRY_W(TRY_W)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .bus           (bus),
        .pulse_width   (pulse_width),
        .form_width    (form_width),
        .settle_cycles (settle_cycles),
        .prog_en       (prog_en),
        .row_drive     (row_drive),
        .row_oe        (row_oe),
        .col_sense     (col_sense),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [ROWS-1:0] drv;
        bit              pulse;
        int              pno;
    } step_t;

    int n_tests = 0;
    int n_fail  = 0;
    bit timed_out = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, ":row_drive"}, row_drive, 0);
        check({tag, ":row_oe"}, row_oe, 1);
        check({tag, ":cmd_ready"}, bus.cmd_ready, 1);
        check({tag, ":rsp_valid"}, bus.rsp_valid, 0);
        check({tag, ":rsp_status"}, bus.rsp_status, 0);
        check({tag, ":rsp_data"}, bus.rsp_data, 0);
        check({tag, ":rsp_tries"}, bus.rsp_tries, 0);
        check({tag, ":busy"}, busy, 0);
    endtask

    // k = number of pulses after which the target cell senses cmd_target.
    task automatic run_cmd(input string name, input int op, input int row, input int col,
                           input bit pol, input bit tgt, input int mt, input int pw, input int fw,
                           input int st, input bit pe, input int k, input int abort_at,
                           input int hold, input logic [COLS-1:0] base);
        step_t           exp_q[$];
        logic [ROWS-1:0] got_q[$];
        logic [ROWS-1:0] oh, pat;
        logic [COLS-1:0] exp_data, cs, snap_data;
        logic [2:0]      snap_status;
        logic [TRY_W-1:0] snap_tries;
        int W, S, M, n, exp_status, exp_tries, gaps, lat, mism, unstable;
        bit fail, chk_data;

        W = (op == 2) ? fw : pw;
        if (W < 1) W = 1;
        S = (st < 1) ? 1 : st;
        M = (mt < 1) ? 1 : mt;
        oh = '0;
        if (row < ROWS) oh[row] = 1'b1;
        pat = pol ? oh : ~oh;
        exp_tries = 0;
        exp_data  = '0;
        chk_data  = 1'b1;
        if (op == 3) begin
            exp_status = 5; chk_data = 1'b0;
        end else if (row >= ROWS || col >= COLS) begin
            exp_status = 4; chk_data = 1'b0;
        end else if (op != 0 && !pe) begin
            exp_status = 2; chk_data = 1'b0;
        end else if (op == 0) begin
            repeat (S) exp_q.push_back('{oh, 1'b0, 0});
            exp_status = 0;
            exp_data   = base;
        end else if (op == 2) begin
            repeat (W) exp_q.push_back('{oh, 1'b1, 1});
            exp_status = 0;
            exp_tries  = 1;
        end else begin
            fail = (k > M);
            n    = fail ? M : k;
            repeat (S) exp_q.push_back('{oh, 1'b0, 0});
            for (int p = 1; p <= n; p++) begin
                repeat (W) exp_q.push_back('{pat, 1'b1, p});
                exp_q.push_back('{'0, 1'b0, p});
                repeat (S) exp_q.push_back('{oh, 1'b0, p});
            end
            exp_status    = fail ? 1 : 0;
            exp_tries     = n;
            exp_data      = base;
            exp_data[col] = fail ? ~tgt : tgt;
        end
        if (abort_at >= 1 && abort_at <= exp_q.size() && exp_q[abort_at-1].pulse) begin
            exp_status = 3;
            exp_tries  = exp_q[abort_at-1].pno;
            if (op == 1) begin
                exp_data      = base;
                exp_data[col] = ~tgt;
            end
            while (exp_q.size() > abort_at) void'(exp_q.pop_back());
        end

        gaps = 0;
        cs = base;
        if (op == 1 && col < COLS) cs[col] = (gaps >= k) ? tgt : ~tgt;
        @(negedge clk);
        bus.cmd_valid     = 1'b1;
        bus.cmd_op        = 2'(op);
        bus.cmd_row       = ROW_W'(row);
        bus.cmd_col       = COL_W'(col);
        bus.cmd_pol       = pol;
        bus.cmd_target    = tgt;
        bus.cmd_max_tries = TRY_W'(mt);
        pulse_width       = CNT_W'(pw);
        form_width        = CNT_W'(fw);
        settle_cycles     = CNT_W'(st);
        prog_en           = pe;
        col_sense         = cs;
        check({name, ":cmd_ready"}, bus.cmd_ready, 1);
        @(posedge clk);
        @(negedge clk);
        bus.cmd_valid     = 1'b0;
        bus.cmd_op        = 2'($urandom);
        bus.cmd_row       = ROW_W'($urandom);
        bus.cmd_col       = COL_W'($urandom);
        bus.cmd_pol       = 1'($urandom);
        bus.cmd_target    = 1'($urandom);
        bus.cmd_max_tries = TRY_W'($urandom);
        pulse_width       = CNT_W'($urandom);
        form_width        = CNT_W'($urandom);
        settle_cycles     = CNT_W'($urandom);

        lat = 0;
        for (int i = 1; i <= 2000; i++) begin
            if (bus.rsp_valid) begin
                lat = i;
                break;
            end
            got_q.push_back(row_drive);
            if (row_drive == '0) gaps++;
            cs = base;
            if (op == 1 && col < COLS) cs[col] = (gaps >= k) ? tgt : ~tgt;
            col_sense = cs;
            prog_en   = (i == abort_at) ? 1'b0 : 1'b1;
            @(negedge clk);
        end
        prog_en = 1'b1;
        if (lat == 0) begin
            check({name, ":timeout"}, 1, 0);
            timed_out = 1'b1;
            return;
        end

        mism = 0;
        for (int j = 0; j < exp_q.size() && j < got_q.size(); j++)
            if (got_q[j] !== exp_q[j].drv) mism++;
        check({name, ":latency"}, lat, exp_q.size() + 1);
        check({name, ":trace"}, mism, 0);
        check({name, ":status"}, bus.rsp_status, exp_status);
        check({name, ":tries"}, bus.rsp_tries, exp_tries);
        if (chk_data) check({name, ":data"}, bus.rsp_data, exp_data);
        check({name, ":resp_drive"}, row_drive, 0);
        check({name, ":resp_busy"}, busy, 1);

        snap_status = bus.rsp_status;
        snap_data   = bus.rsp_data;
        snap_tries  = bus.rsp_tries;
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'd0;
        bus.cmd_row   = '0;
        bus.cmd_col   = '0;
        unstable = 0;
        for (int h = 0; h < hold; h++) begin
            @(negedge clk);
            if (!bus.rsp_valid || bus.cmd_ready || bus.rsp_status !== snap_status ||
                bus.rsp_data !== snap_data || bus.rsp_tries !== snap_tries || row_drive != '0)
                unstable++;
        end
        check({name, ":hold_stable"}, unstable, 0);
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        bus.rsp_ready = 1'b0;
        check({name, ":xfer_ready"}, bus.cmd_ready, 1);
        check({name, ":xfer_valid"}, bus.rsp_valid, 0);
        bus.cmd_valid = 1'b0;
    endtask

    initial begin
        int op, row, col, mt, pw, fw, st, k, ab, hold;
        bit pe;
        bus.cmd_valid = 1'b0; bus.rsp_ready = 1'b0;
        bus.cmd_op = '0; bus.cmd_row = '0; bus.cmd_col = '0;
        bus.cmd_pol = 1'b0; bus.cmd_target = 1'b0; bus.cmd_max_tries = '0;
        pulse_width = '0; form_width = '0; settle_cycles = '0;
        prog_en = 1'b1; col_sense = '0;
        repeat (2) @(negedge clk);
        check_reset_vals("reset");
        rst_n = 1'b1;

        //       name         op row col pol tgt mt pw fw st pe  k  ab hold base
        run_cmd("read_r3",     0, 3,  0, 0,  0,  0, 0, 0, 4, 1, 0, 0, 1, 6'h25);
        if (!timed_out) run_cmd("pv_ok2",  1, 2, 5, 1, 1, 4, 3, 0, 2, 1, 2, 0, 0, 6'h0A);
        if (!timed_out) run_cmd("pv_fail", 1, 2, 1, 0, 0, 3, 2, 0, 1, 1, 99, 0, 2, 6'h33);
        if (!timed_out) run_cmd("pv_nopulse", 1, 4, 0, 1, 1, 5, 4, 0, 3, 1, 0, 0, 0, 6'h10);
        if (!timed_out) run_cmd("form_ilk", 2, 1, 0, 1, 0, 0, 0, 5, 0, 0, 0, 0, 0, 6'h3F);
        if (!timed_out) run_cmd("pv_ilk",  1, 1, 0, 1, 0, 2, 5, 0, 1, 0, 1, 0, 0, 6'h3F);
        if (!timed_out) run_cmd("form_abort", 2, 5, 0, 1, 0, 0, 0, 10, 0, 1, 0, 2, 1, 6'h01);
        if (!timed_out) run_cmd("pv_abort", 1, 0, 3, 0, 1, 4, 6, 0, 2, 1, 3, 4, 0, 6'h02);
        if (!timed_out) run_cmd("range_row", 0, 7, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 0, 6'h00);
        if (!timed_out) run_cmd("range_col", 1, 0, 6, 1, 1, 2, 2, 0, 2, 0, 1, 0, 0, 6'h00);
        if (!timed_out) run_cmd("bad_op",  3, 7, 7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'h00);
        if (!timed_out) run_cmd("pv_w0",   1, 3, 2, 1, 1, 0, 0, 0, 0, 1, 1, 0, 0, 6'h00);
        if (!timed_out) run_cmd("form_w0", 2, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 6'h15);
        if (!timed_out) run_cmd("hold20",  0, 5, 0, 0, 0, 0, 0, 0, 2, 1, 0, 0, 20, 6'h2A);

        for (int t = 0; t < 60 && !timed_out; t++) begin
            op   = $urandom_range(0, 9);
            op   = (op < 3) ? 0 : (op < 7) ? 1 : (op < 9) ? 2 : 3;
            row  = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            col  = ($urandom_range(0, 9) == 0) ? $urandom_range(6, 7) : $urandom_range(0, 5);
            mt   = $urandom_range(0, 5);
            pw   = $urandom_range(0, 5);
            fw   = $urandom_range(0, 5);
            st   = $urandom_range(0, 5);
            pe   = ($urandom_range(0, 9) != 0);
            k    = ($urandom_range(0, 5) == 0) ? 99 : $urandom_range(0, 4);
            ab   = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 20) : 0;
            hold = $urandom_range(0, 3);
            run_cmd($sformatf("rnd%0d", t), op, row, col, 1'($urandom), 1'($urandom),
                    mt, pw, fw, st, pe, k, ab, hold, COLS'($urandom));
        end

        if (!timed_out) begin
            @(negedge clk);
            bus.cmd_valid = 1'b1; bus.cmd_op = 2'd2; bus.cmd_row = ROW_W'(2);
            form_width = CNT_W'(40); prog_en = 1'b1;
            @(posedge clk);
            @(negedge clk);
            bus.cmd_valid = 1'b0;
            repeat (3) @(negedge clk);
            check("rst:pre_drive", row_drive, 6'h04);
            #2 rst_n = 1'b0;
            #1 check_reset_vals("rst_mid_pulse");
            @(negedge clk);
            rst_n = 1'b1;
            run_cmd("post_reset", 0, 1, 4, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 6'h11);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
